// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry UART transmit path.
// mode_t is the same 2-bit operating-mode encoding that fsm_controller drives.
package telemetry_pkg;

    localparam int         PKT_LEN        = 5;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef logic [1:0] mode_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOAD,
        SEQ_SEND,
        SEQ_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // The checksum covers the three payload bytes only, never the header.
    function automatic logic [7:0] calc_chk(input mode_t mode, input logic [7:0] x, input logic [7:0] y);
        return {6'b0, mode} ^ x ^ y;
    endfunction

endpackage

// File: rtl/uart_telemetry_tx_if.sv
// Request/snapshot inputs and serial/status outputs of the telemetry transmitter.
interface uart_telemetry_tx_if;

    logic                 send;
    telemetry_pkg::mode_t state;
    logic [7:0]           x;
    logic [7:0]           y;
    logic                 tx;
    logic                 busy;
    logic                 done;

    modport master (output send, state, x, y, input tx, busy, done);
    modport slave  (input send, state, x, y, output tx, busy, done);

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser. A start accepted in the last stop-bit cycle chains
// the next frame with no idle gap.
module uart_tx_byte
    import telemetry_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift_r;
    logic             tx_nxt;
    logic             bit_end;
    logic             load;

    assign bit_end   = (baud_cnt == LAST_TICK);
    assign byte_done = (state == TX_STOP) && bit_end;
    assign ready     = (state == TX_IDLE) || byte_done;
    assign load      = start && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx       <= tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (load) shift_r <= data;
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt + 1'b1;
        bit_cnt_nxt  = bit_cnt;
        unique case (state)
            TX_IDLE: begin
                baud_cnt_nxt = '0;
                if (start) state_nxt = TX_START;
            end
            TX_START: begin
                if (bit_end) state_nxt = TX_DATA;
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_cnt_nxt = '0;
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = TX_STOP;
                end
            end
            TX_STOP: begin
                if (bit_end) state_nxt = start ? TX_START : TX_IDLE;
            end
        endcase
        // Both counters restart on every state entry, including STOP -> START.
        if (state_nxt != state) begin
            baud_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
        end
        // tx is registered from the next state so the line never glitches.
        unique case (state_nxt)
            TX_START: tx_nxt = 1'b0;
            TX_DATA:  tx_nxt = shift_r[bit_cnt_nxt];
            default:  tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_telemetry_tx.sv
// Telemetry reporter: sends {HEADER, mode, x, y, checksum} over UART on request
// or on a free-running period tick, with at most one request held pending.
module uart_telemetry_tx
    import telemetry_pkg::*;
#(
    parameter int         CLKS_PER_BIT  = 10417,
    parameter int         PERIOD_CYCLES = 10_000_000,
    parameter logic [7:0] HEADER        = HEADER_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    uart_telemetry_tx_if.slave  bus
);

    localparam int              PER_W    = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'((PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0);

    seq_state_t       seq_state, seq_nxt;
    logic [2:0]       byte_idx, byte_idx_nxt;
    logic             pending, pending_nxt;
    logic [PER_W-1:0] period_cnt;
    logic             tick;
    logic             trigger;
    logic             start_pkt;
    mode_t            mode_r;
    logic [7:0]       x_r, y_r, chk_r;
    logic             ser_start, ser_ready, ser_byte_done;
    logic [7:0]       ser_data;

    assign tick    = (PERIOD_CYCLES != 0) && (period_cnt == PER_LAST);
    assign trigger = bus.send || tick;
    // A packet may begin from IDLE, or straight out of DONE so a pending request follows without a gap.
    assign start_pkt = ser_ready &&
                       (((seq_state == SEQ_IDLE) && trigger) ||
                        ((seq_state == SEQ_DONE) && (trigger || pending)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if ((PERIOD_CYCLES == 0) || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq_state <= SEQ_IDLE;
            byte_idx  <= '0;
            pending   <= 1'b0;
        end else begin
            seq_state <= seq_nxt;
            byte_idx  <= byte_idx_nxt;
            pending   <= pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (start_pkt) begin
            mode_r <= bus.state;
            x_r    <= bus.x;
            y_r    <= bus.y;
        end
        if (seq_state == SEQ_LOAD) chk_r <= calc_chk(mode_r, x_r, y_r);
    end

    always_comb begin
        seq_nxt      = seq_state;
        byte_idx_nxt = byte_idx;
        ser_start    = 1'b0;
        ser_data     = HEADER;
        unique case (seq_state)
            SEQ_IDLE: begin
                if (start_pkt) begin
                    ser_start = 1'b1;
                    seq_nxt   = SEQ_LOAD;
                end
            end
            SEQ_LOAD: begin
                seq_nxt      = SEQ_SEND;
                byte_idx_nxt = '0;
            end
            SEQ_SEND: begin
                if (ser_byte_done) begin
                    if (byte_idx == 3'(PKT_LEN - 1)) begin
                        seq_nxt = SEQ_DONE;
                    end else begin
                        ser_start    = 1'b1;
                        byte_idx_nxt = byte_idx + 3'd1;
                        case (byte_idx)
                            3'd0:    ser_data = {6'b0, mode_r};
                            3'd1:    ser_data = x_r;
                            3'd2:    ser_data = y_r;
                            default: ser_data = chk_r;
                        endcase
                    end
                end
            end
            SEQ_DONE: begin
                if (start_pkt) begin
                    ser_start = 1'b1;
                    seq_nxt   = SEQ_LOAD;
                end else begin
                    seq_nxt = SEQ_IDLE;
                end
            end
        endcase
        // Single-entry request buffer: extra triggers while one is held are dropped.
        pending_nxt = pending;
        if (start_pkt) begin
            pending_nxt = 1'b0;
        end else if (trigger && (seq_state != SEQ_IDLE)) begin
            pending_nxt = 1'b1;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .reset     (reset),
        .start     (ser_start),
        .data      (ser_data),
        .tx        (bus.tx),
        .ready     (ser_ready),
        .byte_done (ser_byte_done)
    );

    assign bus.done = (seq_state == SEQ_DONE);
    assign bus.busy = (seq_state == SEQ_LOAD) || (seq_state == SEQ_SEND) ||
                      ((seq_state == SEQ_DONE) && pending);

endmodule

// File: tb/tb_uart_telemetry_tx.sv
// Bench for uart_telemetry_tx: packet-level timeline model, byte receiver,
// directed scenarios, randomized traffic, and a periodic-report instance.
module tb_uart_telemetry_tx;
    import telemetry_pkg::*;

    localparam int CPB     = 4;
    localparam int PKT_CYC = 50 * CPB;
    localparam int HIST    = 8192;

    logic clk = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    always #5 clk = ~clk;

    uart_telemetry_tx_if bus_a();
    uart_telemetry_tx_if bus_b();

    uart_telemetry_tx #(.CLKS_PER_BIT(CPB), .PERIOD_CYCLES(0), .HEADER(8'hA5)) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a));
    uart_telemetry_tx #(.CLKS_PER_BIT(CPB), .PERIOD_CYCLES(300), .HEADER(8'hA5)) dut_b (
        .clk(clk), .reset(reset_b), .bus(bus_b));

    int n_chk = 0;
    int n_err = 0;

    // Timeline model: n counts active edges; a packet started at edge m_s owns edges up to m_s+PKT_CYC.
    int         n = 0;
    bit         m_active = 0;
    bit         m_pending = 0;
    int         m_s = 0;
    logic [7:0] m_pkt [PKT_LEN];
    logic [7:0] exp_q [$];

    bit         rx_busy = 0;
    int         rx_c = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_log [$];

    int   busy_cnt = 0, done_cnt = 0, done_n = 0, busy_rises = 0;
    bit   prev_busy = 0;
    logic tx_hist [HIST];

    int nb = 0, b_done = 0, b_idle_bad = 0;
    int b_starts [$];
    bit prev_busy_b = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_log.size()) return {24'b0, rx_log[i]};
        return 32'hDEAD;
    endfunction

    task automatic model_start(input int at);
        m_active  = 1;
        m_pending = 0;
        m_s       = at;
        m_pkt[0]  = 8'hA5;
        m_pkt[1]  = {6'b0, bus_a.state};
        m_pkt[2]  = bus_a.x;
        m_pkt[3]  = bus_a.y;
        m_pkt[4]  = m_pkt[1] ^ m_pkt[2] ^ m_pkt[3];
        for (int i = 0; i < PKT_LEN; i++) exp_q.push_back(m_pkt[i]);
    endtask

    task automatic model_reset();
        m_active  = 0;
        m_pending = 0;
        rx_busy   = 0;
        exp_q.delete();
    endtask

    task automatic model_edge();
        if (!reset_a) begin
            model_reset();
        end else begin
            n++;
            if (m_active && (n == m_s + PKT_CYC + 1)) begin
                if (m_pending || bus_a.send) model_start(n);
                else m_active = 0;
            end else if (m_active) begin
                if (bus_a.send) m_pending = 1;
            end else if (bus_a.send) begin
                model_start(n);
            end
        end
    endtask

    task automatic check_outputs();
        logic e_tx, e_busy, e_done;
        int d, k;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (m_active) begin
            d = n - m_s;
            if (d < PKT_CYC) begin
                k = d / CPB;
                e_busy = 1'b1;
                case (k % 10)
                    0:       e_tx = 1'b0;
                    9:       e_tx = 1'b1;
                    default: e_tx = m_pkt[k / 10][(k % 10) - 1];
                endcase
            end else begin
                e_busy = m_pending;
                e_done = 1'b1;
            end
        end
        check_eq("tx", bus_a.tx, e_tx);
        check_eq("busy", bus_a.busy, e_busy);
        check_eq("done", bus_a.done, e_done);
    endtask

    task automatic rx_step();
        logic [31:0] want;
        if (rx_busy) begin
            rx_c++;
            if (rx_c >= 6 && rx_c <= 34 && ((rx_c - 6) % 4) == 0) rx_sh[(rx_c - 6) / 4] = bus_a.tx;
            if (rx_c == 38) begin
                check_eq("rx_stop", bus_a.tx, 1);
                rx_log.push_back(rx_sh);
                want = 32'hDEAD;
                if (exp_q.size() > 0) want = {24'b0, exp_q.pop_front()};
                check_eq("rx_byte", rx_sh, want);
            end
            if (rx_c == 39) rx_busy = 0;
        end else if (bus_a.tx == 1'b0) begin
            rx_busy = 1;
            rx_c    = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        if (reset_b) nb++;
        @(negedge clk);
        check_outputs();
        tx_hist[n % HIST] = bus_a.tx;
        if (reset_a) rx_step();
        if (bus_a.busy) busy_cnt++;
        if (bus_a.busy && !prev_busy) busy_rises++;
        prev_busy = bus_a.busy;
        if (bus_a.done) begin
            done_cnt++;
            done_n = n;
        end
        if (reset_b) begin
            if (bus_b.busy && !prev_busy_b) b_starts.push_back(nb);
            prev_busy_b = bus_b.busy;
            if (!bus_b.busy && bus_b.tx !== 1'b1) b_idle_bad++;
            if (bus_b.done) b_done++;
        end
    endtask

    task automatic pulse_send(input logic [1:0] st, input logic [7:0] xv, input logic [7:0] yv);
        bus_a.state = st;
        bus_a.x     = xv;
        bus_a.y     = yv;
        bus_a.send  = 1'b1;
        cycle();
        bus_a.send  = 1'b0;
    endtask

    initial begin
        int s;
        int bad;
        logic [7:0] s1_exp [5];
        int b_exp [3];
        s1_exp = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27};
        b_exp  = '{300, 600, 900};

        bus_a.send = 1'b0; bus_a.state = '0; bus_a.x = '0; bus_a.y = '0;
        bus_b.send = 1'b0; bus_b.state = '0; bus_b.x = '0; bus_b.y = '0;
        #1;
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (3) cycle();
        check_eq("rst_tx", bus_a.tx, 1);
        check_eq("rst_busy", bus_a.busy, 0);
        check_eq("rst_done", bus_a.done, 0);
        check_eq("rst_b_tx", bus_b.tx, 1);
        check_eq("rst_b_busy", bus_b.busy, 0);
        reset_a = 1'b1;
        repeat (2) cycle();

        // Scenario 1 + 6: reference packet, latency and bit timing
        busy_cnt = 0; done_cnt = 0; rx_log.delete();
        pulse_send(2'b01, 8'h12, 8'h34);
        s = n;
        check_eq("s1_tx_start", bus_a.tx, 0);
        check_eq("s1_busy_start", bus_a.busy, 1);
        repeat (PKT_CYC + 5) cycle();
        check_eq("s1_busy_cycles", busy_cnt, PKT_CYC);
        check_eq("s1_done_cnt", done_cnt, 1);
        check_eq("s1_done_cycle", done_n - s + 1, 201);
        check_eq("s1_nbytes", rx_log.size(), 5);
        for (int i = 0; i < 5; i++) check_eq("s1_byte", rx_at(i), {24'b0, s1_exp[i]});
        bad = 0;
        for (int k = 0; k < 50; k++)
            for (int j = 1; j < CPB; j++)
                if (tx_hist[(s + CPB * k + j) % HIST] !== tx_hist[(s + CPB * k) % HIST]) bad++;
        check_eq("s6_bit_stable", bad, 0);
        for (int b = 0; b < 5; b++) check_eq("s6_stop_bit", tx_hist[(s + 40 * b + 36) % HIST], 1);
        check_eq("s6_stop0_end", tx_hist[(s + 39) % HIST], 1);
        check_eq("s6_byte1_start", tx_hist[(s + 40) % HIST], 0);
        check_eq("s6_pre_idle", tx_hist[(s - 1) % HIST], 1);

        // Scenario 2: snapshot is immune to mid-packet input changes
        rx_log.delete();
        pulse_send(2'b01, 8'h12, 8'h34);
        repeat (80) cycle();
        bus_a.x = 8'hFF;
        repeat (PKT_CYC - 75) cycle();
        check_eq("s2_x_held", rx_at(2), 32'h12);
        check_eq("s2_chk_held", rx_at(4), 32'h27);
        rx_log.delete();
        pulse_send(2'b01, 8'hFF, 8'h34);
        repeat (PKT_CYC + 5) cycle();
        check_eq("s2_x_new", rx_at(2), 32'hFF);
        check_eq("s2_chk_new", rx_at(4), 32'hCA);

        // Scenario 3: three extra requests while busy collapse into one pending packet
        rx_log.delete(); done_cnt = 0; busy_rises = 0;
        pulse_send(2'b10, 8'h3C, 8'h99);
        for (int r = 0; r < 3; r++) begin
            repeat (49) cycle();
            pulse_send(2'b11, 8'(8'h40 + r), 8'h01);
        end
        repeat (260) cycle();
        check_eq("s3_done_cnt", done_cnt, 2);
        check_eq("s3_busy_rises", busy_rises, 1);
        check_eq("s3_nbytes", rx_log.size(), 10);

        // Scenario 5: asynchronous abort mid-packet, then a clean packet
        pulse_send(2'b10, 8'h5A, 8'hC3);
        repeat (60) cycle();
        reset_a = 1'b0;
        #1;
        check_eq("s5_abort_tx", bus_a.tx, 1);
        check_eq("s5_abort_busy", bus_a.busy, 0);
        check_eq("s5_abort_done", bus_a.done, 0);
        model_reset();
        done_cnt = 0;
        repeat (3) cycle();
        reset_a = 1'b1;
        repeat (5) cycle();
        check_eq("s5_no_done", done_cnt, 0);
        rx_log.delete();
        pulse_send(2'b11, 8'h81, 8'h7E);
        repeat (PKT_CYC + 5) cycle();
        check_eq("s5_nbytes", rx_log.size(), 5);
        check_eq("s5_hdr", rx_at(0), 32'hA5);
        check_eq("s5_mode", rx_at(1), 32'h03);
        check_eq("s5_chk", rx_at(4), 32'hFC);

        // Randomized traffic against the timeline model
        for (int i = 0; i < 1500; i++) begin
            bus_a.state = 2'($urandom);
            bus_a.x     = 8'($urandom);
            bus_a.y     = 8'($urandom);
            bus_a.send  = ($urandom_range(0, 199) < 3);
            cycle();
        end
        bus_a.send = 1'b0;
        repeat (2 * PKT_CYC + 20) cycle();
        check_eq("rand_drain", exp_q.size(), 0);

        // Scenario 4: periodic reports on the second instance
        bus_b.state = 2'b01; bus_b.x = 8'h22; bus_b.y = 8'h33;
        reset_b = 1'b1;
        repeat (1000) cycle();
        check_eq("s4_nstarts", b_starts.size(), 3);
        for (int i = 0; i < 3; i++)
            check_eq("s4_start_cycle", (i < b_starts.size()) ? b_starts[i] : -1, b_exp[i]);
        check_eq("s4_idle_high", b_idle_bad, 0);
        check_eq("s4_done_cnt", b_done, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
